// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
// Also used by other arbiters that reuse rr_pick4.
package rr_bus_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(
    input logic [SEL_W-1:0] i
  );
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit
// scanning from ptr upward, modulo 4.
module rr_pick4
  import rr_bus_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] c;

  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = ptr + SEL_W'(k);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter sharing one 32-bit write port among four
// requesters, with burst lock and owner-idle timeout.
module rr_bus_arbiter4
  import rr_bus_arbiter4_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic [31:0]      d0,
  input  logic [31:0]      d1,
  input  logic [31:0]      d2,
  input  logic [31:0]      d3,
  input  logic             o_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             o_valid,
  output logic [31:0]      o_data,
  output logic             o_last,
  output logic [SEL_W-1:0] o_src
);

  localparam bit TO_EN = (IDLE_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n, ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             any;
  logic [SEL_W-1:0] idx;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = LOCK;
          gnt_n   = idx2onehot(idx);
          sel_n   = idx;
          cnt_n   = '0;
        end
      end
      LOCK: begin
        if (req[sel]) begin
          cnt_n = '0;
          if (o_ready && last[sel]) begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = sel + SEL_W'(1);
          end
        end else if (TO_EN) begin
          // Owner went quiet: release once the idle run is long enough
          if (cnt == TO_LAST) begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = sel + SEL_W'(1);
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_data = d0;
    unique case (sel)
      2'd0: o_data = d0;
      2'd1: o_data = d1;
      2'd2: o_data = d2;
      2'd3: o_data = d3;
      default: ;
    endcase
  end

  assign o_valid = gnt[sel] & req[sel];
  assign o_last  = last[sel] & o_valid;
  assign o_src   = sel;

endmodule

// File: doc/rr_bus_arbiter4.md
Name: rr_bus_arbiter4

Overview:
- Round-robin arbiter that shares one 32-bit downstream write port (memory/peripheral bus) among four requesters.
- Supports multi-beat bursts: the grant locks to the owner until it sends a beat marked last.
- Drives the 2-bit select of the shared 4:1 32-bit data mux and exposes a valid/ready handshake downstream.
- Sits between the requester stages and the bus interface in the pipelined datapath.

Parameters:
- IDLE_TIMEOUT, 16, consecutive owner-idle cycles (req low while granted) before the lock is forcibly released; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > IDLE_TIMEOUT.

Ports:
- clk  in  1  single system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  4  per-requester beat request; req[i] high means d_i holds a valid beat.
- last  in  4  per-requester end-of-burst flag; sampled only with req[i].
- d0, d1, d2, d3  in  32 each  requester data.
- o_ready  in  1  downstream accepts the beat this cycle.
- gnt  out  4  registered one-hot grant (all zero when idle).
- sel  out  2  registered owner index; mux select.
- o_valid  out  1  gnt[sel] & req[sel].
- o_data  out  32  data of requester sel.
- o_last  out  1  last[sel] & o_valid.
- o_src  out  2  equals sel; tags the beat source.

Behaviour:
- Reset (rstn low, async): state=IDLE, gnt=0, sel=0, ptr=0, timeout counter=0, o_valid=0, o_last=0, o_data=d0 (don't-care).
- FSM state IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning from ptr, ptr+1, … mod 4.
  - Next cycle: gnt one-hot for the winner, sel=winner, state=LOCK.
  - Arbitration latency is 1 cycle; no beat can be accepted in IDLE.
- FSM state LOCK:
  - A beat is accepted when o_valid & o_ready; requester i observes acceptance as gnt[i]&req[i]&o_ready.
  - Accepted beat with last[sel]=1: next cycle gnt=0, state=IDLE, ptr=sel+1 mod 4 (wraps 3→0).
  - Accepted beat with last=0: hold the grant, clear the timeout counter.
  - o_ready low: hold the grant. o_data and o_last follow the owner's inputs combinationally. Requesters must hold d/last stable until accepted.
  - req[sel] low: increment the timeout counter. When it reaches IDLE_TIMEOUT (counter==IDLE_TIMEOUT-1 and req[sel] still low), release exactly as on a last beat (ptr=sel+1, IDLE). The counter is cleared on any cycle with req[sel] high.
  - Requests from non-owners are ignored in LOCK. They are not dropped; they wait for IDLE.
- Fairness: a requester with req held continuously is granted within 3 bursts of other owners (plus timeouts).
- Simultaneous requests in IDLE: ptr order decides. Example: ptr=2, req=4'b1011 → winner 3.
- Last beat accepted while other requests are pending: there is a one-cycle IDLE bubble, then re-arbitration with the updated ptr.
- Reset mid-burst: grant drops asynchronously and the burst is abandoned. Requesters must restart.
- All outputs except o_valid, o_data and o_last are registered. The o_valid, o_data and o_last path is combinational from req/last/d through the mux.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, LOCK}
  - constant N_REQ=4
  - constant SEL_W=2
  - a function converting index to one-hot.
- Natural sub-module: rr_pick4, a combinational round-robin picker (inputs req[3:0], ptr[1:0]; outputs any, idx[1:0]). It is reused by other arbiters in the design.
- The data path uses the team's existing 4-input 32-bit mux, with sel as its select.

Test Plan:
1. Reset then single requester: req=4'b0001, d0=32'hA5A5_0001, last0=1, o_ready=1. Expect gnt=4'b0001 one cycle later, o_data=A5A5_0001 accepted, gnt=0 the cycle after, ptr=1.
2. Round-robin order: req=4'b1111 held, every beat last=1, o_ready=1. Grant sequence 0,1,2,3,0, with one idle cycle between grants.
3. Burst lock with backpressure: owner 2 sends 3 beats (last only on the 3rd), o_ready toggles 1,0,1,0,1, and req0 is held throughout. gnt stays 4'b0100 until the 3rd beat is accepted, then req0 is granted.
4. Timeout: IDLE_TIMEOUT=4, owner 1 sends 1 non-last beat then drops req. Grant releases after exactly 4 idle cycles; ptr=2.
5. Pointer wrap and priority: ptr=3, req=4'b0101 in IDLE. Winner is 0 (scan 3→0).
6. Async reset mid-burst: assert rstn=0 between clock edges during LOCK. gnt=0 and o_valid=0 immediately. After release, a fresh request to 0 is granted first (ptr=0).
